wb_arbiter: RTL
===============

// Module: wb_arbiter
//
// PURPOSE
// - Parametrised write-back stage: collects results from NUM_SRC execution units (ALU, CSR, MEM, ...)
//   and delivers them one per cycle to the register manager.
// - Each source has its own small FIFO with a valid/ok handshake, so simultaneous results are buffered.
//   No result is dropped.
// - Sources are served round-robin. An exception flush discards all pending results.
//
// PARAMETERS
// - NUM_SRC     3      number of result sources (>=2)
// - FIFO_DEPTH  2      entries per source FIFO (power of 2, >=2)
// - XLEN        xlen   result width (from cpu_parameters)
//
// PORTS
// - clk          in   1              clock
// - rst_n        in   1              synchronous active-low reset
// - src_res      in   NUM_SRC*XLEN   per-source result data
// - src_rd       in   NUM_SRC*5      per-source destination register
// - src_v        in   NUM_SRC        per-source result valid
// - src_ok       out  NUM_SRC        per-source accept (ready)
// - flush        in   1              exception flush (from CSR)
// - result       out  XLEN           write-back data
// - rd           out  5              write-back destination register
// - result_v     out  1              write-back valid, one-cycle pulse per result
// - busy         out  1              any FIFO non-empty or result_v high
//
// BEHAVIOUR
// - Reset: sampled only on a clk edge with rst_n=0.
//   - All FIFOs empty; RR pointer = 0.
//   - result = 0, rd = 0, result_v = 0.
//   - src_ok = 0 while rst_n=0; busy = 0 after reset.
// - Handshake:
//   - src_ok[i] = rst_n & !flush & !full[i]. No bypass: a full FIFO is not ready even in a cycle it pops.
//   - Push to FIFO i occurs when src_v[i] & src_ok[i]. Sources hold data stable until accepted.
// - Arbitration:
//   - Each cycle, among non-empty FIFOs, grant the first one at or after the RR pointer (wrapping modulo NUM_SRC).
//   - Pop that FIFO's head. Then set the pointer to grant+1 (mod NUM_SRC).
//   - If no FIFO is non-empty, the pointer holds.
// - Latency:
//   - A result pushed in cycle t is eligible for grant in t+1.
//   - With an uncontended grant in t+1, result/rd/result_v are registered and visible in t+2.
//   - Throughput is 1 result per cycle.
// - Output registers:
//   - result_v is high exactly one cycle per emitted result.
//   - result and rd hold their last values when result_v = 0.
// - x0 filter: a granted entry with rd = 0 is popped and consumes the grant slot and the RR advance.
//   result_v stays 0 for it.
// - Flush (synchronous, highest priority):
//   - In a cycle with flush=1, all FIFOs are cleared, no push and no pop occur, and the RR pointer holds.
//   - The next cycle has result_v = 0. A result_v already registered in the flush cycle is still visible in that cycle.
// - Simultaneous push and pop on a non-full FIFO keeps the occupancy unchanged. Pointers wrap modulo FIFO_DEPTH.
// - A FIFO is empty when occupancy = 0 and full when occupancy = FIFO_DEPTH. Occupancy counter width is $clog2(FIFO_DEPTH)+1.
// - Reset mid-operation discards all pending entries, with the same values as at power-up reset.
//
// STRUCTURE
// - cpu_parameters package:
//   - add typedef wb_entry_t = struct packed {logic[xlen-1:0] res; logic[4:0] rd;}
//   - add localparam WB_NUM_SRC = 3.
// - Sub-module wb_fifo #(DEPTH): single-source synchronous FIFO of wb_entry_t.
//   - Signals: push/pop/clear, full/empty, head.
//   - One instance per source, via generate.
// - The top level contains only the round-robin arbiter, the x0 filter and the output registers.
//
// TESTING
// - Single: src1 pushes res=0xDEADBEEF, rd=5 at t -> result_v=1, result=0xDEADBEEF, rd=5 at t+2 only; busy=0 at t+3.
// - Contention: srcs 0,1,2 push rd=1,2,3 at t -> rd=1,2,3 on t+2,t+3,t+4; the next single push from src0 is granted immediately.
// - Full: src0 pushes every cycle while src1/src2 are kept non-empty -> src_ok[0] drops to 0 when 2 entries are held.
//   No entry is lost or duplicated; output order per source is FIFO.
// - Flush: 3 entries pending, flush=1 at t -> result_v=0 from t+1, busy=0 at t+1, src_ok=0 at t, src_ok all 1 at t+1.
// - x0: src2 pushes rd=0 at t -> result_v stays 0; the RR pointer advances past src2.
// - Reset mid-stream: rst_n=0 with entries pending -> result=0, rd=0, result_v=0, busy=0 the cycle after.
//   The first post-reset grant goes to the lowest-index non-empty source.

Source files
------------

// File: rtl/cpu_parameters.sv
// Shared CPU-wide parameters and the write-back entry type carried through the result FIFOs.
package cpu_parameters;

    localparam int xlen       = 32;
    localparam int WB_NUM_SRC = 3;
    localparam int REG_IDX_W  = 5;

    typedef struct packed {
        logic [xlen-1:0]      res;
        logic [REG_IDX_W-1:0] rd;
    } wb_entry_t;

    // Round-robin successor: index after cur, wrapping at n.
    function automatic int rr_next(input int cur, input int n);
        return (cur == n - 1) ? 0 : cur + 1;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Single-source result FIFO of wb_entry_t with synchronous clear.
// Latency: a push becomes visible on head/empty the next cycle.
// Backpressure: full is raised at DEPTH entries; the caller must not push while full or pop while empty.
module wb_fifo
    import cpu_parameters::*;
#(
    parameter int DEPTH = 2
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      push,
    input  wb_entry_t push_dat,
    input  logic      pop,
    input  logic      clear,
    output logic      full,
    output logic      empty,
    output wb_entry_t head
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    wb_entry_t          mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;

    assign empty = (count == '0);
    assign full  = (count == CNT_W'(DEPTH));
    assign head  = mem[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clear) begin
            mem[wr_ptr] <= push_dat;
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter: per-source result FIFOs drained round-robin into one registered result port.
// Latency: push in t -> result_v in t+2 when uncontended; sustained one result per cycle.
// Backpressure: src_ok[i] drops while FIFO i is full, during flush and while rst_n is low.
module wb_arbiter
    import cpu_parameters::*;
#(
    parameter int NUM_SRC    = WB_NUM_SRC,
    parameter int FIFO_DEPTH = 2,
    parameter int XLEN       = xlen
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_SRC*XLEN-1:0]     src_res,
    input  logic [NUM_SRC*5-1:0]        src_rd,
    input  logic [NUM_SRC-1:0]          src_v,
    output logic [NUM_SRC-1:0]          src_ok,
    input  logic                        flush,
    output logic [XLEN-1:0]             result,
    output logic [4:0]                  rd,
    output logic                        result_v,
    output logic                        busy
);

    localparam int PTR_W = $clog2(NUM_SRC);

    logic [NUM_SRC-1:0] push;
    logic [NUM_SRC-1:0] pop;
    logic [NUM_SRC-1:0] full;
    logic [NUM_SRC-1:0] empty;
    wb_entry_t          head [NUM_SRC];

    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   grant_idx;
    logic               grant_vld;
    wb_entry_t          grant_dat;

    generate
        for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
            wb_entry_t in_dat;

            assign in_dat.res = src_res[i*XLEN +: XLEN];
            assign in_dat.rd  = src_rd[i*5 +: 5];

            // No bypass: a full FIFO stays not-ready even in a cycle it is popped.
            assign src_ok[i] = rst_n & ~flush & ~full[i];
            assign push[i]   = src_v[i] & src_ok[i];
            assign pop[i]    = grant_vld & ~flush & (grant_idx == PTR_W'(i));

            wb_fifo #(
                .DEPTH (FIFO_DEPTH)
            ) u_fifo (
                .clk      (clk),
                .rst_n    (rst_n),
                .push     (push[i]),
                .push_dat (in_dat),
                .pop      (pop[i]),
                .clear    (flush),
                .full     (full[i]),
                .empty    (empty[i]),
                .head     (head[i])
            );
        end
    endgenerate

    // Scan from farthest to nearest offset so the first non-empty source at or after rr_ptr wins.
    always_comb begin
        logic [PTR_W-1:0] cand;
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            cand = PTR_W'((int'(rr_ptr) + k) % NUM_SRC);
            if (!empty[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
    end

    assign grant_dat = head[grant_idx];

    // x0 entries are consumed like any other grant but never reach the register file.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr   <= '0;
            result   <= '0;
            rd       <= '0;
            result_v <= 1'b0;
        end else begin
            result_v <= 1'b0;
            if (!flush && grant_vld) begin
                rr_ptr <= PTR_W'(rr_next(int'(grant_idx), NUM_SRC));
                if (grant_dat.rd != 5'd0) begin
                    result   <= grant_dat.res;
                    rd       <= grant_dat.rd;
                    result_v <= 1'b1;
                end
            end
        end
    end

    assign busy = ~(&empty) | result_v;

endmodule
